condlogic_pipe: RTL and testbench
=================================

# condlogic_pipe

Execute-stage conditional-execution unit of the pipelined CPU. It holds the Decode→Execute control register, the NZCV status-flag register, and the Execute→Memory control register. It evaluates the instruction's condition field against the stored flags through the existing `condcheck` module. It then gates register write, memory write, PC redirect and flag update so that a failed-condition instruction has no architectural effect.

## Interface
Parameters:
- none (all widths fixed by the ISA).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `CondD`  in  4  condition field of the instruction in Decode.
- `FlagWriteD`  in  2  bit1 = update N,Z; bit0 = update C,V.
- `RegWriteD`, `MemWriteD`, `MemtoRegD`, `PCSrcD`, `BranchD`  in  1 each  Decode control signals.
- `FlushE`  in  1  from the hazard unit; inserts a bubble into Execute.
- `ALUFlagsE`  in  4  {N,Z,C,V} produced by the ALU for the instruction in Execute.
- `CondExE`  out  1  condition passed for the instruction in Execute.
- `BranchTakenE`  out  1  `BranchE & CondExE`; goes to PC mux and hazard unit.
- `FlagsE`  out  4  current flag register {N,Z,C,V}.
- `RegWriteM`, `MemWriteM`, `MemtoRegM`, `PCSrcM`  out  1 each  gated controls for Memory stage.

## Operation
- The D→E register captures `CondD`, `FlagWriteD`, `RegWriteD`, `MemWriteD`, `MemtoRegD`, `PCSrcD` and `BranchD` each cycle.
- When `FlushE`=1, it instead loads a bubble: all control bits 0, `FlagWriteE`=00, `CondE`=4'b1110.
- `condcheck` is instantiated with `Cond`=`CondE`, `Flags`=`FlagsE`.
- `CondExE` = `condcheck.CondEx`, forced to 0 when `CondE`=4'b1111 (reserved encoding, never executes).
- Flag bit order is [3]=N, [2]=Z, [1]=C, [0]=V.
- Flag register updates:
  - N,Z ← `ALUFlagsE[3:2]` when `FlagWriteE[1] & CondExE`.
  - C,V ← `ALUFlagsE[1:0]` when `FlagWriteE[0] & CondExE`.
  - The two halves update independently; otherwise the register holds.
- The condition is evaluated against the flags before this instruction's own update; an instruction never sees its own flags.
- The E→M register captures:
  - `RegWriteE & CondExE`
  - `MemWriteE & CondExE`
  - `PCSrcE & CondExE`
  - `MemtoRegE` (ungated)
- `BranchTakenE` is combinational from E-stage state; it is not registered here.
- There is no stall input. Execute and Memory advance every cycle.

## Timing
- Reset (async, immediate):
  - all D→E and E→M fields 0, with `CondE`=4'b1110 (AL).
  - `FlagsE`=4'b0000.
  - All outputs 0, including `CondExE`: AL with no controls gives `BranchTakenE`=0.
- Latency:
  - Decode controls appear in E one cycle after capture.
  - Gated controls appear at `*M` one cycle later (2 cycles D→M).
- Flag update is visible on `FlagsE` the cycle after the setting instruction is in E. A dependent conditional instruction directly behind it sees the new flags with no bubble.
- Simultaneous events:
  - `reset` overrides `FlushE`.
  - `FlushE` overrides D inputs.
  - A flushed slot never updates flags or produces M-stage writes.
- Reset asserted mid-operation: in-flight instructions are discarded and flags cleared. The first post-reset instruction evaluates against flags 0000.
- Outputs must be glitch-free with respect to `ALUFlagsE`. `CondExE` depends only on registered state.

## Test plan
- **Reset:** assert `reset` asynchronously between edges → all outputs 0 and `FlagsE`=0000 immediately, before the next edge.
- **Flag set, then conditional:**
  - Cycle 1: `CondD`=1110, `FlagWriteD`=11, `ALUFlagsE`=0100.
  - Cycle 2: `CondD`=0000 (EQ), `RegWriteD`=1.
  - Required: `FlagsE`=0100 and `CondExE`=1 for the EQ instruction, then `RegWriteM`=1.
- **Failed condition:** `FlagsE`=0000, `CondD`=0000, `RegWriteD`=`MemWriteD`=`PCSrcD`=1, `FlagWriteD`=11, `ALUFlagsE`=1111 → `CondExE`=0, all `*M` writes 0, `FlagsE` remains 0000.
- **Partial update:** `FlagsE`=0011, AL, `FlagWriteD`=10, `ALUFlagsE`=1000 → `FlagsE`=1011.
- **Branch and flush:**
  - `BranchD`=1 with `CondD`=0001 (NE) and Z=0 → `BranchTakenE`=1 in E.
  - Same instruction with `FlushE`=1 at capture → `BranchTakenE`=0 and `PCSrcM`=0.
- **Reserved condition:** `CondD`=1111, `RegWriteD`=1 → `CondExE`=0, `RegWriteM`=0.

Source files
------------

// File: rtl/condlogic_pipe.sv
// condlogic_pipe: Execute-stage conditional-execution unit.
// Holds the D->E control register, the NZCV flag register and the E->M
// control register, and gates architectural side effects on the condition.

// condcheck: evaluates a 4-bit condition field against {N,Z,C,V}.
module condcheck (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);
  logic n, z, c, v, ge;

  assign {n, z, c, v} = Flags;
  assign ge           = (n == v);

  // Full decode of the condition field; 1111 is reserved and never passes.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z;
      4'b0001: CondEx = ~z;
      4'b0010: CondEx = c;
      4'b0011: CondEx = ~c;
      4'b0100: CondEx = n;
      4'b0101: CondEx = ~n;
      4'b0110: CondEx = v;
      4'b0111: CondEx = ~v;
      4'b1000: CondEx = ~z & c;
      4'b1001: CondEx = z | ~c;
      4'b1010: CondEx = ge;
      4'b1011: CondEx = ~ge;
      4'b1100: CondEx = ~z & ge;
      4'b1101: CondEx = z | ~ge;
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end
endmodule

module condlogic_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] CondD,
  input  logic [1:0] FlagWriteD,
  input  logic       RegWriteD,
  input  logic       MemWriteD,
  input  logic       MemtoRegD,
  input  logic       PCSrcD,
  input  logic       BranchD,
  input  logic       FlushE,
  input  logic [3:0] ALUFlagsE,
  output logic       CondExE,
  output logic       BranchTakenE,
  output logic [3:0] FlagsE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM,
  output logic       PCSrcM
);

  // vld marks a slot holding a real decoded instruction; reset and flush
  // clear it so an empty slot never reports a passed condition.
  typedef struct packed {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       rw;
    logic       mw;
    logic       m2r;
    logic       pcs;
    logic       br;
    logic       vld;
  } de_t;

  typedef struct packed {
    logic rw;
    logic mw;
    logic m2r;
    logic pcs;
  } em_t;

  de_t        de_d, de_q;
  em_t        em_d, em_q;
  logic [3:0] flags_d, flags_q;
  logic       cc_pass;

  condcheck u_cc (
    .Cond   (de_q.cond),
    .Flags  (flags_q),
    .CondEx (cc_pass)
  );

  // Condition result depends only on registered state (no ALUFlagsE path).
  assign CondExE      = cc_pass & de_q.vld & (de_q.cond != 4'b1111);
  assign BranchTakenE = de_q.br & CondExE;
  assign FlagsE       = flags_q;
  assign RegWriteM    = em_q.rw;
  assign MemWriteM    = em_q.mw;
  assign MemtoRegM    = em_q.m2r;
  assign PCSrcM       = em_q.pcs;

  // D->E next state: capture Decode controls, or a bubble (AL, no effects).
  always_comb begin
    de_d      = '0;
    de_d.cond = 4'b1110;
    if (!FlushE) begin
      de_d.cond = CondD;
      de_d.fw   = FlagWriteD;
      de_d.rw   = RegWriteD;
      de_d.mw   = MemWriteD;
      de_d.m2r  = MemtoRegD;
      de_d.pcs  = PCSrcD;
      de_d.br   = BranchD;
      de_d.vld  = 1'b1;
    end
  end

  // Flag next state: N,Z and C,V halves update independently on pass.
  always_comb begin
    flags_d = flags_q;
    if (de_q.fw[1] && CondExE) flags_d[3:2] = ALUFlagsE[3:2];
    if (de_q.fw[0] && CondExE) flags_d[1:0] = ALUFlagsE[1:0];
  end

  // E->M next state: architectural writes gated by the condition.
  always_comb begin
    em_d.rw  = de_q.rw  & CondExE;
    em_d.mw  = de_q.mw  & CondExE;
    em_d.pcs = de_q.pcs & CondExE;
    em_d.m2r = de_q.m2r;
  end

  // Pipeline and flag registers; reset empties both stages and clears NZCV.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q      <= '0;
      de_q.cond <= 4'b1110;
      em_q      <= '0;
      flags_q   <= 4'b0000;
    end else begin
      de_q    <= de_d;
      em_q    <= em_d;
      flags_q <= flags_d;
    end
  end

endmodule

// File: tb/tb_condlogic_pipe.sv
// Scoreboard bench for condlogic_pipe: stimulus pushes expected responses,
// a negedge monitor pops and compares them.
module tb_condlogic_pipe;
  logic       clk = 1'b0, reset = 1'b0;
  logic [3:0] CondD = 4'b1110;
  logic [1:0] FlagWriteD = 2'b00;
  logic       RegWriteD = 0, MemWriteD = 0, MemtoRegD = 0, PCSrcD = 0, BranchD = 0;
  logic       FlushE = 0;
  logic [3:0] ALUFlagsE = 4'b0000;
  logic       CondExE, BranchTakenE, RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic [3:0] FlagsE;

  condlogic_pipe dut (
    .clk(clk), .reset(reset), .CondD(CondD), .FlagWriteD(FlagWriteD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
    .PCSrcD(PCSrcD), .BranchD(BranchD), .FlushE(FlushE), .ALUFlagsE(ALUFlagsE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE), .FlagsE(FlagsE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .PCSrcM(PCSrcM)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    bit rw, mw, m2r, pcs, br, vld;
  } ins_t;

  typedef struct {
    bit skipcx, cx, bt;
    logic [3:0] fl;
    bit rwm, mwm, m2rm, pcsm;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0;
  bit   done = 0;

  // Reference state: instruction awaiting capture, instruction in E,
  // architectural flags, and M-stage results.
  ins_t       d_pend, e_cur;
  logic [3:0] mflags = 4'b0000, alu_cur = 4'b0000;
  bit         m_rw = 0, m_mw = 0, m_m2r = 0, m_pcs = 0;

  function automatic ins_t bubble();
    ins_t b;
    b = '{cond: 4'b1110, fw: 2'b00, rw: 0, mw: 0, m2r: 0, pcs: 0, br: 0, vld: 0};
    return b;
  endfunction

  function automatic ins_t mk(logic [3:0] c, logic [1:0] fw, bit rw, bit mw,
                              bit m2r, bit pcs, bit br);
    ins_t i;
    i = '{cond: c, fw: fw, rw: rw, mw: mw, m2r: m2r, pcs: pcs, br: br, vld: 1};
    return i;
  endfunction

  // Conditions come in pairs: odd encodings are the negation of the even one.
  function automatic bit cond_ok(logic [3:0] c, logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit e_pass();
    return e_cur.vld && cond_ok(e_cur.cond, mflags);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model of one rising edge: retire E into flags and M, advance D into E.
  task automatic apply_edge();
    bit cx;
    cx = e_pass();
    if (cx && e_cur.fw[1]) mflags[3:2] = alu_cur[3:2];
    if (cx && e_cur.fw[0]) mflags[1:0] = alu_cur[1:0];
    m_rw  = e_cur.rw  && cx;
    m_mw  = e_cur.mw  && cx;
    m_pcs = e_cur.pcs && cx;
    m_m2r = e_cur.m2r;
    e_cur = d_pend;
  endtask

  // One cycle: drive a Decode instruction plus ALU flags for the E instruction.
  task automatic step(ins_t in, bit flush, logic [3:0] alu);
    exp_t e;
    @(posedge clk);
    apply_edge();
    #1;
    CondD = in.cond; FlagWriteD = in.fw; RegWriteD = in.rw; MemWriteD = in.mw;
    MemtoRegD = in.m2r; PCSrcD = in.pcs; BranchD = in.br;
    FlushE = flush; ALUFlagsE = alu;
    d_pend  = flush ? bubble() : in;
    d_pend.vld = !flush;
    alu_cur = alu;
    e.skipcx = !e_cur.vld;
    e.cx   = e_pass();
    e.bt   = e_cur.br && e.cx;
    e.fl   = mflags;
    e.rwm  = m_rw; e.mwm = m_mw; e.m2rm = m_m2r; e.pcsm = m_pcs;
    q.push_back(e);
  endtask

  // Assert reset between edges and check outputs clear before any edge.
  task automatic do_reset();
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk("reset_outputs",
           {CondExE, BranchTakenE, FlagsE, RegWriteM, MemWriteM, MemtoRegM, PCSrcM}, 0);
    CondD = 4'b0000; FlagWriteD = 2'b00; RegWriteD = 0; MemWriteD = 0;
    MemtoRegD = 0; PCSrcD = 0; BranchD = 0; FlushE = 0; ALUFlagsE = 4'b0000;
    @(posedge clk);
    #1 reset = 1'b0;
    mflags = 4'b0000; alu_cur = 4'b0000;
    m_rw = 0; m_mw = 0; m_m2r = 0; m_pcs = 0;
    e_cur  = bubble();
    d_pend = mk(4'b0000, 2'b00, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs to the oldest expectation each cycle.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (!e.skipcx) chk("CondExE", CondExE, e.cx);
        chk("BranchTakenE", BranchTakenE, e.bt);
        chk("FlagsE", FlagsE, e.fl);
        chk("RegWriteM", RegWriteM, e.rwm);
        chk("MemWriteM", MemWriteM, e.mwm);
        chk("MemtoRegM", MemtoRegM, e.m2rm);
        chk("PCSrcM", PCSrcM, e.pcsm);
      end
    end
  end

  initial begin
    ins_t nop, r;
    nop = mk(4'b1110, 2'b00, 0, 0, 0, 0, 0);
    e_cur = bubble(); d_pend = bubble();

    do_reset();

    // Flag set by AL instruction, then EQ consumer directly behind it.
    step(mk(4'b1110, 2'b11, 0, 0, 0, 0, 0), 0, 4'b0000);
    step(mk(4'b0000, 2'b00, 1, 0, 0, 0, 0), 0, 4'b0100);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("dep_flags", FlagsE, 4'b0100);
    chk("dep_condex", CondExE, 1);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("dep_regwm", RegWriteM, 1);

    // Failed EQ with flags 0000: no writes, no flag update.
    do_reset();
    step(mk(4'b0000, 2'b11, 1, 1, 0, 1, 0), 0, 4'b0000);
    step(nop, 0, 4'b1111);
    @(negedge clk);
    chk("fail_condex", CondExE, 0);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("fail_mwrites", {RegWriteM, MemWriteM, PCSrcM}, 0);
    chk("fail_flags", FlagsE, 4'b0000);

    // Partial update: C,V to 11, then only N,Z from 1000.
    do_reset();
    step(mk(4'b1110, 2'b01, 0, 0, 0, 0, 0), 0, 4'b0000);
    step(mk(4'b1110, 2'b10, 0, 0, 0, 0, 0), 0, 4'b0011);
    step(nop, 0, 4'b1000);
    @(negedge clk);
    chk("partial_cv", FlagsE, 4'b0011);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("partial_nz", FlagsE, 4'b1011);

    // NE branch with Z=0 is taken; the same branch flushed is not.
    do_reset();
    step(mk(4'b0001, 2'b00, 0, 0, 0, 1, 1), 0, 4'b0000);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("br_taken", BranchTakenE, 1);
    step(mk(4'b0001, 2'b00, 0, 0, 0, 1, 1), 1, 4'b0000);
    @(negedge clk);
    chk("br_pcsrcm", PCSrcM, 1);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("flush_bt", BranchTakenE, 0);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("flush_pcsrcm", PCSrcM, 0);

    // Reserved condition never executes.
    step(mk(4'b1111, 2'b11, 1, 0, 0, 0, 0), 0, 4'b0000);
    step(nop, 0, 4'b1111);
    @(negedge clk);
    chk("rsv_condex", CondExE, 0);
    step(nop, 0, 4'b0000);
    @(negedge clk);
    chk("rsv_regwm", RegWriteM, 0);
    chk("rsv_flags", FlagsE, 4'b0000);

    // Randomized traffic with occasional flushes and mid-run resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      r = mk(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      step(r, $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
    end

    @(negedge clk);
    #1 done = 1;
    if (q.size() != 0) chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
